// File: rtl/ts_surface_ctrl_if.sv
// Bundle of the event, scan-output and RAM-port signals of ts_surface_ctrl.
// The slave modport is the controller's view; master is the environment's.
interface ts_surface_ctrl_if;
  logic [14:0] now_ts;
  logic        ev_valid;
  logic        ev_ready;
  logic [7:0]  ev_addr;
  logic        clr_start;
  logic        scan_start;
  logic        busy;
  logic        feat_valid;
  logic [7:0]  feat_addr;
  logic [15:0] feat_age;
  logic        scan_done;
  logic        we_a;
  logic [7:0]  addr_a;
  logic [15:0] din_a;
  logic [7:0]  addr_b;
  logic [15:0] dout_b;

  modport slave (
    input  now_ts, ev_valid, ev_addr, clr_start, scan_start, dout_b,
    output ev_ready, busy, feat_valid, feat_addr, feat_age, scan_done,
           we_a, addr_a, din_a, addr_b
  );

  modport master (
    output now_ts, ev_valid, ev_addr, clr_start, scan_start, dout_b,
    input  ev_ready, busy, feat_valid, feat_addr, feat_age, scan_done,
           we_a, addr_a, din_a, addr_b
  );
endinterface

// File: rtl/ts_surface_ctrl.sv
// Time-surface RAM sequencer: clears, writes event timestamps (port A), streams ages (port B).
// Define TS_AGE_SAT_EN to report ages above MAX_AGE as 16'hFFFF.
module ts_surface_ctrl #(
  parameter logic [15:0] MAX_AGE    = 16'h7FFF,
  parameter logic [15:0] EMPTY_WORD = 16'h8000
) (
  input logic               clk,
  input logic               rst,
  ts_surface_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_INIT,
    S_CLEAR,
    S_IDLE,
    S_SCAN,
    S_DRAIN
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_busy;
  logic        r_ev_ready;
  logic        r_clr_we;
  logic        r_scan_rd;
  logic        r_scan_done;

  logic        r_rd_vld;
  logic [7:0]  r_rd_addr;
  logic        r_feat_valid;
  logic [7:0]  r_feat_addr;
  logic [15:0] r_feat_age;

  logic        w_ev_fire;
  logic        w_cnt_last;
  logic [14:0] w_age_raw;
  logic [15:0] w_age;

  assign w_cnt_last = (r_cnt == 8'hFF);
  assign w_ev_fire  = bus.ev_valid & r_ev_ready;

  // Outputs are registered alongside the state so they are valid from the first cycle of each state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_cnt       <= 8'd0;
      r_busy      <= 1'b1;
      r_ev_ready  <= 1'b0;
      r_clr_we    <= 1'b0;
      r_scan_rd   <= 1'b0;
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_state  <= S_CLEAR;
          r_cnt    <= 8'd0;
          r_clr_we <= 1'b1;
        end
        S_CLEAR: begin
          if (w_cnt_last) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_clr_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_ev_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_IDLE: begin
          // Clear has priority; a simultaneous scan request is dropped.
          if (bus.clr_start) begin
            r_state    <= S_CLEAR;
            r_cnt      <= 8'd0;
            r_clr_we   <= 1'b1;
            r_busy     <= 1'b1;
            r_ev_ready <= 1'b0;
          end else if (bus.scan_start) begin
            r_state   <= S_SCAN;
            r_cnt     <= 8'd0;
            r_scan_rd <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_SCAN: begin
          if (w_cnt_last) begin
            r_state   <= S_DRAIN;
            r_cnt     <= 8'd0;
            r_scan_rd <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DRAIN: begin
          if (r_cnt == 8'd1) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_busy      <= 1'b0;
            r_scan_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state    <= S_INIT;
          r_cnt      <= 8'd0;
          r_busy     <= 1'b1;
          r_ev_ready <= 1'b0;
          r_clr_we   <= 1'b0;
          r_scan_rd  <= 1'b0;
        end
      endcase
    end
  end

  assign w_age_raw = bus.now_ts - bus.dout_b[14:0];

  always_comb begin
    w_age = {1'b0, w_age_raw};
    if (bus.dout_b[15]) begin
      w_age = 16'hFFFF;
    end
`ifdef TS_AGE_SAT_EN
    else if ({1'b0, w_age_raw} > MAX_AGE) begin
      w_age = 16'hFFFF;
    end
`endif
  end

  // Two-stage read pipeline: address tag follows the RAM latency, then the age is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld     <= 1'b0;
      r_rd_addr    <= 8'd0;
      r_feat_valid <= 1'b0;
      r_feat_addr  <= 8'd0;
      r_feat_age   <= 16'd0;
    end else begin
      r_rd_vld     <= r_scan_rd;
      r_rd_addr    <= r_scan_rd ? r_cnt : 8'd0;
      r_feat_valid <= r_rd_vld;
      r_feat_addr  <= r_rd_vld ? r_rd_addr : 8'd0;
      r_feat_age   <= r_rd_vld ? w_age : 16'd0;
    end
  end

  assign bus.ev_ready   = r_ev_ready;
  assign bus.busy       = r_busy;
  assign bus.scan_done  = r_scan_done;
  assign bus.feat_valid = r_feat_valid;
  assign bus.feat_addr  = r_feat_addr;
  assign bus.feat_age   = r_feat_age;

  assign bus.we_a   = r_clr_we | w_ev_fire;
  assign bus.addr_a = r_clr_we  ? r_cnt :
                      w_ev_fire ? bus.ev_addr : 8'd0;
  assign bus.din_a  = r_clr_we  ? EMPTY_WORD :
                      w_ev_fire ? {1'b0, bus.now_ts} : 16'd0;
  assign bus.addr_b = r_scan_rd ? r_cnt : 8'd0;

endmodule

// File: doc/ts_surface_ctrl.md
# ts_surface_ctrl

Sequencer and port arbiter for the 256×16 per-pixel timestamp RAM of the 16×16 time surface. It writes the current timestamp for each accepted DVS event through RAM port A. It clears the whole surface to the "empty" sentinel through port A after reset and on request. It sweeps RAM port B to stream per-pixel event ages to the feature extractor.

## Interface
- `MAX_AGE`, default 16'h7FFF: age saturation threshold; used only when `TS_AGE_SAT_EN` is defined.
- `EMPTY_WORD`, default 16'h8000: sentinel written by clear; bit 15 set marks a pixel with no event.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `now_ts` in 15: free-running timestamp, wraps modulo 2^15.
- `ev_valid` in 1: event offered.
- `ev_ready` out 1: event accepted when `ev_valid && ev_ready`.
- `ev_addr` in 8: pixel address {y[3:0], x[3:0]}.
- `clr_start` in 1: one-cycle clear request.
- `scan_start` in 1: one-cycle scan request.
- `busy` out 1: FSM not in IDLE.
- `feat_valid` out 1: age output valid.
- `feat_addr` out 8: pixel address of the age output.
- `feat_age` out 16: age of that pixel.
- `scan_done` out 1: one-cycle pulse after the last age output.
- `we_a` out 1, `addr_a` out 8, `din_a` out 16: RAM port A.
- `addr_b` out 8, `dout_b` in 16: RAM port B; read latency is 1 cycle.

## Operation
- FSM states: INIT, CLEAR, IDLE, SCAN, DRAIN.
- **Reset.** `rst` high forces INIT and zeroes the counter. INIT lasts one cycle after `rst` falls, then the FSM enters CLEAR. RAM contents are not reset, so a clear always follows reset.
- **CLEAR.** 256 cycles. Each cycle `we_a`=1, `addr_a`=counter, `din_a`=`EMPTY_WORD`. `ev_ready`=0. Counter 0..255, then the FSM goes to IDLE.
- **IDLE.**
  - `clr_start` goes to CLEAR with the counter at 0.
  - Otherwise `scan_start` goes to SCAN with the counter at 0.
  - If both are high in the same cycle, clear wins and the scan request is dropped.
  - Start pulses received in any other state are ignored.
- **SCAN.** 256 cycles. `addr_b`=counter (0..255), then the FSM goes to DRAIN.
- **DRAIN.** 2 cycles: flushes the read pipeline, pulses `scan_done`, then returns to IDLE.
- **Events.** `ev_ready`=1 in IDLE, SCAN and DRAIN; 0 in INIT and CLEAR.
  - An accepted event drives `we_a`=1, `addr_a`=`ev_addr`, `din_a`={1'b0, `now_ts`} in the same cycle (combinational).
  - Events and scan run concurrently because they use different ports.
  - A write and a port-B read to the same address in the same cycle return the old word.
- **Age computation**, for each `dout_b` word w:
  - If w[15]=1: `feat_age`=16'hFFFF (empty).
  - Otherwise: `feat_age`={1'b0, (`now_ts` − w[14:0]) mod 2^15}, using `now_ts` sampled at the output register.
- **Idle port values.** `addr_b`=0 outside SCAN. `we_a`=0 unless in CLEAR or an event is accepted. `addr_a` and `din_a` are 0 when `we_a`=0.

## Timing
- Event write takes effect at the clock edge where the handshake completes. No back-pressure outside CLEAR/INIT.
- Scan latency: address k is driven in SCAN cycle k; `dout_b` arrives at k+1; `feat_valid`/`feat_addr`=k/`feat_age` are registered at k+2.
- Scan output is 256 consecutive `feat_valid` cycles. `scan_done` is high in the cycle after `feat_addr`=255 is valid.
- Full scan is 256 + 2 + 1 cycles from `scan_start` to return to IDLE. Clear is 256 cycles.
- Values while `rst` is high:
  - `busy`=1 (INIT counts as busy).
  - `ev_ready`=0.
  - `feat_valid`=0, `feat_addr`=0, `feat_age`=0, `scan_done`=0.
  - `we_a`=0, `addr_a`=0, `din_a`=0, `addr_b`=0.
- Reset asserted mid-scan or mid-clear aborts immediately. The age pipeline is flushed (no stale `feat_valid`), and a full clear runs afterwards.
- Counter wrap: the 8-bit counter terminates on 255. It never rolls over into a second pass.

## Configuration
- `TS_AGE_SAT_EN` defined: non-empty ages greater than `MAX_AGE` are output as 16'hFFFF, the same value as empty pixels.
- `TS_AGE_SAT_EN` undefined: the raw modular age is output, and `MAX_AGE` is unused.

## Test plan
- **Reset recovery:** release `rst` → `busy`=1 for 257 cycles, exactly 256 writes of 16'h8000 to addresses 0..255, `ev_ready` rises in the first IDLE cycle.
- **Empty scan:** `scan_start` after init → 256 `feat_valid` beats, `feat_addr` 0..255 in order, every `feat_age`=16'hFFFF, `scan_done` one cycle after beat 255.
- **Event then scan:** event at address 8'h35 with `now_ts`=100, then a scan with `now_ts`=130 at beat 8'h35 → that beat shows `feat_age`=30; all other pixels show 16'hFFFF.
- **Timestamp wrap:** stored ts 15'h7FF0, `now_ts`=15'h0010 at readout → `feat_age`=16'h0020.
- **Arbitration:**
  - Events during SCAN are accepted, with `ev_ready`=1 throughout.
  - `clr_start` and `scan_start` in the same IDLE cycle → CLEAR only, and `ev_ready`=0 for 256 cycles.
  - `scan_start` during CLEAR is ignored: no `feat_valid`.
- **Mid-scan reset and saturation:**
  - Assert `rst` at scan beat 100 → no `feat_valid`/`scan_done` after the reset edge, and a full clear follows.
  - With `TS_AGE_SAT_EN` and `MAX_AGE`=50, an age of 51 reads 16'hFFFF and an age of 50 reads 50.
